// File: rtl/scheduler_sram_controller.sv
// Sequencer for one core's SchedulerSRAM: buffers spike packets in a small FIFO,
// writes them into the SRAM, and on each global tick clears, advances and presents the next slot.
module scheduler_sram_controller #(
    parameter int NUM_AXONS  = 256,
    parameter int NUM_TICKS  = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(NUM_AXONS),
    localparam int TW = $clog2(NUM_TICKS),
    localparam int PW = AW + TW,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          core_busy,
    input  logic [PW-1:0] packet_in,
    input  logic          packet_valid,
    output logic          packet_ready,
    output logic          sram_wen,
    output logic          sram_clr,
    output logic [PW-1:0] sram_packet,
    output logic [TW-1:0] sram_read_address,
    output logic          axons_ready,
    output logic          tick_overrun,
    output logic [CW-1:0] fifo_count
);

    localparam int PTRW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_CLEAR   = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;

    logic [2:0]      state;
    logic            tick_pending;
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [PW-1:0]   fifo_mem [FIFO_DEPTH];
    logic            push;
    logic            pop;

    function automatic logic [TW-1:0] addr_inc(input logic [TW-1:0] a);
        return a + TW'(1);
    endfunction

    // Strobes decode purely from registered state and occupancy so the SRAM sees glitch-free controls.
    assign packet_ready = (state != S_INIT) && (fifo_count < CW'(FIFO_DEPTH));
    assign sram_wen     = (state == S_IDLE) && (fifo_count != '0);
    assign sram_clr     = (state == S_INIT) || (state == S_CLEAR);
    assign axons_ready  = (state == S_PRESENT);
    assign sram_packet  = fifo_mem[rd_ptr];

    assign push = packet_valid && packet_ready;
    assign pop  = sram_wen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_INIT;
            sram_read_address <= '0;
            tick_pending      <= 1'b0;
            tick_overrun      <= 1'b0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_count        <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    sram_read_address <= addr_inc(sram_read_address);
                    if (sram_read_address == TW'(NUM_TICKS - 1))
                        state <= S_IDLE;
                end
                S_IDLE: begin
                    if (tick_pending && !core_busy)
                        state <= S_CLEAR;
                end
                S_CLEAR:   state <= S_ADVANCE;
                S_ADVANCE: begin
                    sram_read_address <= addr_inc(sram_read_address);
                    state             <= S_PRESENT;
                end
                S_PRESENT: state <= S_IDLE;
                default:   state <= S_INIT;
            endcase

            // A tick landing on the clearing cycle becomes the next pending tick rather than an overrun.
            if (state == S_CLEAR) begin
                tick_pending <= tick;
            end else if (tick) begin
                if (tick_pending)
                    tick_overrun <= 1'b1;
                else
                    tick_pending <= 1'b1;
            end

            if (push)
                wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTRW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= packet_in;
    end

endmodule
